mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. It owns the HI/LO registers.
- It is the responding end of the hazard unit's stall protocol. It consumes the same 3-bit start code that the hazard unit inspects, and it drives busy back to it.
- It executes mult/multu/div/divu over a fixed multi-cycle latency, and services mthi/mtlo writes.
- HI/LO are presented to the EX-stage result mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, number of cycles busy stays high for mult/multu (minimum 1).
- DIV_CYCLES, 10, number of cycles busy stays high for div/divu (minimum 1).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  3  operation launch code, sampled each rising edge: 1=mult, 2=multu, 3=div, 4=divu; 0, 5, 6, 7 = no operation.
- A  input  32  rs operand (forwarded); also the data source for mthi/mtlo.
- B  input  32  rt operand (forwarded).
- mthi  input  1  write A into HI.
- mtlo  input  1  write A into LO.
- busy  output  1  high while an operation is in flight; goes to the hazard unit.
- HI  output  32  current HI register.
- LO  output  32  current LO register.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; busy=0, HI=0, LO=0, cycle counter=0, pending result=0.
  - Reset asserted mid-operation aborts the operation immediately; no result is ever committed.
- States: IDLE and RUN.
- IDLE:
  - If start is 1–4 at a rising edge: operands are latched, the result is computed into pending HI/LO, the counter is loaded with MULT_CYCLES or DIV_CYCLES, and the state moves to RUN.
  - busy is a registered output. It goes high in the cycle after the start edge, so it is 0 during the start cycle itself. The hazard unit covers that cycle by decoding start directly.
- RUN:
  - The counter decrements every edge.
  - The state returns to IDLE on the edge where the counter reaches 1. On that same edge HI/LO take the pending values and busy falls.
  - busy is therefore high for exactly N cycles, and the new HI/LO are visible in the first cycle busy=0.
- Arithmetic:
  - mult: signed 32x32 to 64-bit product; HI = product[63:32], LO = product[31:0].
  - multu: same as mult, unsigned.
  - div: signed; LO = quotient, truncated toward zero; HI = remainder, which takes the sign of the dividend A.
  - divu: unsigned; LO = quotient, HI = remainder.
  - div with A=0x80000000, B=0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divide by zero (B=0): the unit still runs DIV_CYCLES with busy high; HI/LO keep their prior values (no commit).
- mthi/mtlo:
  - Accepted only in IDLE and only when start is not 1–4. A is written into HI and/or LO on the next edge.
  - mthi and mtlo together write A to both registers.
  - Writes are single-cycle and do not assert busy.
- Simultaneous and illegal events:
  - start 1–4 together with mthi/mtlo in IDLE: start wins, the move is ignored.
  - start or mthi/mtlo arriving while in RUN: ignored; the in-flight operation and its pending result are unaffected. The hazard unit normally prevents this case.
  - start codes 0 and 5–7: no effect in any state.
- HI/LO change only on reset, on the commit edge, or on an accepted mthi/mtlo edge.

Test Plan:
- Reset, then idle: busy=0, HI=LO=0; start=5/6/7 for several cycles keeps busy=0 and HI/LO unchanged.
- mult, A=0xFFFFFFFE (-2), B=3: busy high for exactly 5 cycles starting the cycle after start; HI=0xFFFFFFFF, LO=0xFFFFFFFA in the first busy=0 cycle. multu with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- div, A=-7, B=2: after 10 busy cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu, A=7, B=2 gives LO=3, HI=1. div, A=0x80000000, B=-1 gives LO=0x80000000, HI=0.
- Divide by zero: set HI=0x11, LO=0x22 via mthi/mtlo, then divu with B=0: busy high for 10 cycles, and afterwards HI=0x11, LO=0x22.
- Collisions: start=1 with mtlo=1, A=0x55 in the same cycle gives the mult result (mtlo ignored). mthi with A=0x99 during RUN is ignored. A second start=3 during RUN is ignored, and busy falls after the original 5 cycles.
- Reset at the 3rd busy cycle of a mult: busy drops immediately (asynchronously) and HI/LO read 0. A subsequent start works normally.

Source files
------------

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit owning HI/LO; runs mult/multu/div/divu over a fixed
// latency, reports busy to the hazard unit and services mthi/mtlo moves.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic          commit_q, commit_d;
  logic          busy_q, busy_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;

  logic          is_start_s, is_mult_s, div_by_zero_s;
  logic [63:0]   prod_s;
  logic [31:0]   abs_a_s, abs_b_s, div_a_s, div_b_s, quot_s, rem_s;
  logic [31:0]   res_hi_s, res_lo_s;

  assign is_start_s    = (start >= 3'd1) && (start <= 3'd4);
  assign is_mult_s     = (start == 3'd1) || (start == 3'd2);
  assign div_by_zero_s = (B == 32'd0);

  // Result datapath; signed divide works on magnitudes so MIN_INT / -1 wraps cleanly.
  always_comb begin
    prod_s   = 64'd0;
    abs_a_s  = A[31] ? (32'd0 - A) : A;
    abs_b_s  = B[31] ? (32'd0 - B) : B;
    div_a_s  = (start == 3'd3) ? abs_a_s : A;
    div_b_s  = (start == 3'd3) ? abs_b_s : B;
    if (div_by_zero_s) begin
      div_b_s = 32'd1;
    end else begin
      div_b_s = div_b_s;
    end
    quot_s   = div_a_s / div_b_s;
    rem_s    = div_a_s % div_b_s;
    res_hi_s = 32'd0;
    res_lo_s = 32'd0;
    case (start)
      3'd1: begin
        prod_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        res_hi_s = prod_s[63:32];
        res_lo_s = prod_s[31:0];
      end
      3'd2: begin
        prod_s   = {32'd0, A} * {32'd0, B};
        res_hi_s = prod_s[63:32];
        res_lo_s = prod_s[31:0];
      end
      3'd3: begin
        res_lo_s = (A[31] ^ B[31]) ? (32'd0 - quot_s) : quot_s;
        res_hi_s = A[31] ? (32'd0 - rem_s) : rem_s;
      end
      3'd4: begin
        res_lo_s = quot_s;
        res_hi_s = rem_s;
      end
      default: begin
        res_hi_s = 32'd0;
        res_lo_s = 32'd0;
      end
    endcase
  end

  // Next-state logic: launch in IDLE, count down in RUN, commit on the last edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    commit_d  = commit_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (is_start_s) begin
          state_d   = RUN;
          busy_d    = 1'b1;
          cnt_d     = is_mult_s ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          pend_hi_d = res_hi_s;
          pend_lo_d = res_lo_s;
          commit_d  = is_mult_s || !div_by_zero_s;
        end else begin
          if (mthi) hi_d = A;
          else      hi_d = hi_q;
          if (mtlo) lo_d = A;
          else      lo_d = lo_q;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (commit_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and HI/LO registers; reset aborts any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      commit_q  <= 1'b0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      commit_q  <= commit_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed, table-driven bench for mult_div_unit: arithmetic vectors plus hand-written
// sequences for divide-by-zero, collisions and mid-operation reset.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic [2:0]  start;
  logic [31:0] A, B;
  logic        mthi, mtlo;
  logic        busy;
  logic [31:0] HI, LO;

  int passed = 0;
  int total  = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cycles;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Launch one op at a negedge, count busy cycles (bounded), then check HI/LO.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int cycles,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cnt;
    @(negedge clk);
    start = op; A = a; B = b;
    @(negedge clk);
    start = 3'd0; A = 32'hDEAD_BEEF; B = 32'h1234_5678;
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check({name, " busy_cycles"}, 32'(cnt), 32'(cycles));
    check({name, " HI"}, HI, exp_hi);
    check({name, " LO"}, LO, exp_lo);
  endtask

  task automatic move(input logic hi_en, input logic lo_en, input logic [31:0] a);
    @(negedge clk);
    mthi = hi_en; mtlo = lo_en; A = a;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
  endtask

  initial begin
    int cnt;
    vecs[0] = '{3'd1, 32'hFFFF_FFFE, 32'd3,          5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{3'd2, 32'hFFFF_FFFE, 32'd3,          5,  32'h0000_0002, 32'hFFFF_FFFA};
    vecs[2] = '{3'd3, 32'hFFFF_FFF9, 32'd2,          10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd4, 32'd7,         32'd2,          10, 32'h0000_0001, 32'h0000_0003};
    vecs[4] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'h0000_0000};
    vecs[6] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001};
    vecs[7] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};

    reset = 1'b1; start = 3'd0; A = 32'd0; B = 32'd0; mthi = 1'b0; mtlo = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset HI", HI, 32'd0);
    check("reset LO", LO, 32'd0);

    // Illegal start codes must have no effect.
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      start = 3'(5 + (i % 3)); A = 32'hABCD_0000 + 32'(i); B = 32'd3;
      @(negedge clk);
      if (busy) cnt++;
    end
    start = 3'd0;
    check("illegal start busy", 32'(cnt), 32'd0);
    check("illegal start HI", HI, 32'd0);
    check("illegal start LO", LO, 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].cycles, vecs[i].exp_hi, vecs[i].exp_lo);
    end

    // Divide by zero keeps prior HI/LO.
    move(1'b1, 1'b0, 32'h11);
    move(1'b0, 1'b1, 32'h22);
    check("mthi", HI, 32'h11);
    check("mtlo", LO, 32'h22);
    run_op("divu by zero", 3'd4, 32'd5, 32'd0, 10, 32'h11, 32'h22);
    run_op("div by zero", 3'd3, 32'hFFFF_FFF0, 32'd0, 10, 32'h11, 32'h22);

    move(1'b1, 1'b1, 32'h77);
    check("mthi+mtlo HI", HI, 32'h77);
    check("mthi+mtlo LO", LO, 32'h77);

    // start wins over mtlo in the same cycle.
    @(negedge clk);
    start = 3'd1; mtlo = 1'b1; A = 32'h55; B = 32'd2;
    @(negedge clk);
    start = 3'd0; mtlo = 1'b0;
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("start+mtlo cycles", 32'(cnt), 32'd5);
    check("start+mtlo HI", HI, 32'd0);
    check("start+mtlo LO", LO, 32'hAA);

    // mthi and a second start during RUN are ignored.
    @(negedge clk);
    start = 3'd1; A = 32'd3; B = 32'd4;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      mthi  = (i == 0);
      start = (i == 1) ? 3'd3 : 3'd0;
      A     = (i == 0) ? 32'h99 : ((i == 1) ? 32'd100 : 32'd3);
      B     = (i == 1) ? 32'd7 : 32'd4;
    end
    check("run collisions cycles", 32'(cnt), 32'd5);
    check("run collisions HI", HI, 32'd0);
    check("run collisions LO", LO, 32'd12);

    // Reset in the third busy cycle aborts with no commit.
    @(negedge clk);
    start = 3'd1; A = 32'hFFFF_FFFE; B = 32'd3;
    @(negedge clk);
    start = 3'd0;
    repeat (2) @(negedge clk);
    check("busy before abort", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort HI", HI, 32'd0);
    check("abort LO", LO, 32'd0);
    #1 reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check("after abort busy", 32'(cnt), 32'd0);
    check("after abort LO", LO, 32'd0);
    run_op("post reset divu", 3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
